sound_scheduler: RTL

- Owns the single speaker PWM pin.
- Accepts sound event requests from the game logic: game over, crash and checkpoint.
- Arbitrates between them by fixed priority and sequences the winning sound as a burst of square-wave beeps separated by silent gaps.
- Sits between the game FSM / collision logic and the board audio output, replacing per-sound free-running PWM generators.

---
 rtl/sound_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sound_scheduler.sv
// Speaker sound scheduler: latches sound requests, picks the highest-priority one and
// plays it as a burst of square-wave beeps separated by silent gaps on the single PWM pin.
module sound_scheduler #(
  parameter logic [14:0] GO_HALF  = 15'd20000,
  parameter logic [3:0]  GO_BEEPS = 4'd4,
  parameter logic [14:0] CR_HALF  = 15'd8000,
  parameter logic [3:0]  CR_BEEPS = 4'd2,
  parameter logic [14:0] CP_HALF  = 15'd4000,
  parameter logic [3:0]  CP_BEEPS = 4'd1,
  parameter logic [23:0] BEEP_LEN = 24'd5000000,
  parameter logic [23:0] GAP_LEN  = 24'd2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_gameover,
  input  logic       req_crash,
  input  logic       req_checkpoint,
  input  logic       mute,
  output logic       pwm,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, TONE, GAP, DONE} state_t;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_CP   = 2'd1;
  localparam logic [1:0] ID_CR   = 2'd2;
  localparam logic [1:0] ID_GO   = 2'd3;

  state_t      state_reg, state_next;
  logic [1:0]  active_id_reg, active_id_next;
  logic [3:0]  beeps_reg, beeps_next;
  logic [23:0] dur_reg, dur_next;
  logic [14:0] tone_reg, tone_next;
  logic        pwm_reg, pwm_next;

  logic [2:0]  req_vec;
  logic [2:0]  pending;
  logic [2:0]  grant;
  logic [1:0]  start_id;
  logic        preempt;

  function automatic logic [14:0] half_of(input logic [1:0] id);
    case (id)
      ID_GO:   return GO_HALF;
      ID_CR:   return CR_HALF;
      default: return CP_HALF;
    endcase
  endfunction

  function automatic logic [3:0] beeps_of(input logic [1:0] id);
    case (id)
      ID_GO:   return GO_BEEPS;
      ID_CR:   return CR_BEEPS;
      default: return CP_BEEPS;
    endcase
  endfunction

  // Bit 2 = game over, bit 1 = crash, bit 0 = checkpoint; a request on the grant
  // cycle re-arms the flag so the sound replays afterwards.
  assign req_vec = {req_gameover, req_crash, req_checkpoint};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pending
      logic flag_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          flag_reg <= 1'b0;
        end else begin
          flag_reg <= req_vec[gi] | (flag_reg & ~grant[gi]);
        end
      end
      assign pending[gi] = flag_reg;
    end
  endgenerate

  assign preempt = ((state_reg == TONE) || (state_reg == GAP)) &&
                   (active_id_reg != ID_GO) && pending[2];

  always_comb begin
    state_next     = state_reg;
    active_id_next = active_id_reg;
    beeps_next     = beeps_reg;
    dur_next       = dur_reg;
    tone_next      = tone_reg;
    pwm_next       = pwm_reg;
    grant          = 3'b000;
    start_id       = ID_NONE;

    case (state_reg)
      IDLE: begin
        if (pending[2]) begin
          start_id = ID_GO;
          grant    = 3'b100;
        end else if (pending[1]) begin
          start_id = ID_CR;
          grant    = 3'b010;
        end else if (pending[0]) begin
          start_id = ID_CP;
          grant    = 3'b001;
        end
      end

      TONE: begin
        if (preempt) begin
          start_id = ID_GO;
          grant    = 3'b100;
        end else begin
          if (tone_reg == 15'd0) begin
            pwm_next  = ~pwm_reg;
            tone_next = half_of(active_id_reg) - 15'd1;
          end else begin
            tone_next = tone_reg - 15'd1;
          end
          if (dur_reg == 24'd0) begin
            pwm_next = 1'b0;
            if (beeps_reg == 4'd1) begin
              state_next = DONE;
            end else begin
              beeps_next = beeps_reg - 4'd1;
              dur_next   = GAP_LEN - 24'd1;
              state_next = GAP;
            end
          end else begin
            dur_next = dur_reg - 24'd1;
          end
        end
      end

      GAP: begin
        if (preempt) begin
          start_id = ID_GO;
          grant    = 3'b100;
        end else begin
          pwm_next = 1'b0;
          if (dur_reg == 24'd0) begin
            dur_next   = BEEP_LEN - 24'd1;
            tone_next  = half_of(active_id_reg) - 15'd1;
            state_next = TONE;
          end else begin
            dur_next = dur_reg - 24'd1;
          end
        end
      end

      DONE: begin
        state_next     = IDLE;
        active_id_next = ID_NONE;
      end

      default: begin
        state_next     = IDLE;
        active_id_next = ID_NONE;
        pwm_next       = 1'b0;
      end
    endcase

    // A grant (fresh or preempting) always starts the sound from the top of its first beep.
    if (start_id != ID_NONE) begin
      state_next     = TONE;
      active_id_next = start_id;
      beeps_next     = beeps_of(start_id);
      dur_next       = BEEP_LEN - 24'd1;
      tone_next      = half_of(start_id) - 15'd1;
      pwm_next       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      active_id_reg <= ID_NONE;
      beeps_reg     <= 4'd0;
      dur_reg       <= 24'd0;
      tone_reg      <= 15'd0;
      pwm_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      active_id_reg <= active_id_next;
      beeps_reg     <= beeps_next;
      dur_reg       <= dur_next;
      tone_reg      <= tone_next;
      pwm_reg       <= pwm_next;
    end
  end

  assign pwm       = pwm_reg & ~mute;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign active_id = active_id_reg;

endmodule
